pc_fetch_sequencer: RTL and testbench

- Fetch-side counterpart of the branch-target address adder. It owns the 64-bit program counter and consumes resolved branch information from execute.
- Each cycle it advances the PC by 4, holds it on stall, or redirects it to a branch target it computes from the branch PC and the raw immediate.
- On a redirect it issues a flush pulse and inserts fetch bubbles for the IF/ID stages.
- Sits between the EX-stage branch unit and instruction memory in the pipelined LEGv8 CPU.

---
 rtl/pc_fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Fetch-side PC owner: advances by 4, holds on stall, or redirects to a resolved
// branch target, with a flush pulse and a configurable run of fetch bubbles.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_PC      = 64'd0,
    parameter int unsigned BUBBLE_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [1:0]       br_kind,
    input  logic [63:0]      br_pc,
    input  logic [25:0]      br_imm,
    input  logic [63:0]      br_reg,
    output logic [63:0]      pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic             align_err,
    output logic [CNT_W-1:0] redirect_count
);

    localparam int unsigned BCNT_W = 3;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [63:0]         pc_q, pc_d;
    logic                fetch_valid_q, fetch_valid_d;
    logic                flush_q, flush_d;
    logic                align_err_q, align_err_d;
    logic [CNT_W-1:0]    redirect_count_q, redirect_count_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;

    logic                redirect_c;
    logic [63:0]         target_c;
    logic [63:0]         b_off_c;
    logic [63:0]         cb_off_c;

    // Branch target: sign-extended word offsets for B/CB, word-aligned register for BR
    always_comb begin
        b_off_c  = {{36{br_imm[25]}}, br_imm, 2'b00};
        cb_off_c = {{43{br_imm[18]}}, br_imm[18:0], 2'b00};
        case (br_kind)
            2'b00:   target_c = br_pc + b_off_c;
            2'b01:   target_c = br_pc + cb_off_c;
            default: target_c = {br_reg[63:2], 2'b00};
        endcase
    end

    assign redirect_c = br_valid & br_taken & (br_kind != 2'b11);

    // Next-state: redirect beats stall beats normal advance
    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        fetch_valid_d    = fetch_valid_q;
        flush_d          = 1'b0;
        align_err_d      = align_err_q;
        redirect_count_d = redirect_count_q;
        bcnt_d           = bcnt_q;

        if (redirect_c) begin
            pc_d    = target_c;
            flush_d = 1'b1;
            if (redirect_count_q != {CNT_W{1'b1}}) begin
                redirect_count_d = redirect_count_q + CNT_W'(1);
            end
            if ((br_kind == 2'b10) && (br_reg[1:0] != 2'b00)) begin
                align_err_d = 1'b1;
            end
            if (BUBBLE_CYCLES == 0) begin
                state_d       = ST_RUN;
                fetch_valid_d = 1'b1;
            end else begin
                state_d       = ST_BUBBLE;
                bcnt_d        = BCNT_W'(BUBBLE_CYCLES - 1);
                fetch_valid_d = 1'b0;
            end
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    pc_d          = pc_q + 64'd4;
                    fetch_valid_d = 1'b1;
                end
                ST_BUBBLE: begin
                    // Leaving the bubble fetches the held target itself, no +4
                    if (bcnt_q == '0) begin
                        state_d       = ST_RUN;
                        fetch_valid_d = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q - BCNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            fetch_valid_q    <= 1'b1;
            flush_q          <= 1'b0;
            align_err_q      <= 1'b0;
            redirect_count_q <= '0;
            bcnt_q           <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            fetch_valid_q    <= fetch_valid_d;
            flush_q          <= flush_d;
            align_err_q      <= align_err_d;
            redirect_count_q <= redirect_count_d;
            bcnt_q           <= bcnt_d;
        end
    end

    assign pc             = pc_q;
    assign fetch_valid    = fetch_valid_q;
    assign flush          = flush_q;
    assign align_err      = align_err_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Three differently-configured sequencers share one stimulus stream and are
// compared every cycle against a behavioural fetch model.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic [1:0]  br_kind;
    logic [63:0] br_pc;
    logic [25:0] br_imm;
    logic [63:0] br_reg;

    logic [63:0] pc0, pc1, pc2;
    logic        fv0, fv1, fv2;
    logic        fl0, fl1, fl2;
    logic        ae0, ae1, ae2;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;
    logic [15:0] cnt2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(.RESET_PC(64'h1000), .BUBBLE_CYCLES(1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
        .br_kind(br_kind), .br_pc(br_pc), .br_imm(br_imm), .br_reg(br_reg),
        .pc(pc0), .fetch_valid(fv0), .flush(fl0), .align_err(ae0), .redirect_count(cnt0));

    pc_fetch_sequencer #(.RESET_PC(64'h1000), .BUBBLE_CYCLES(3), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
        .br_kind(br_kind), .br_pc(br_pc), .br_imm(br_imm), .br_reg(br_reg),
        .pc(pc1), .fetch_valid(fv1), .flush(fl1), .align_err(ae1), .redirect_count(cnt1));

    pc_fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF0), .BUBBLE_CYCLES(0), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_taken(br_taken),
        .br_kind(br_kind), .br_pc(br_pc), .br_imm(br_imm), .br_reg(br_reg),
        .pc(pc2), .fetch_valid(fv2), .flush(fl2), .align_err(ae2), .redirect_count(cnt2));

    // Reference model state: left = invalid fetch cycles still owed after a redirect
    logic [63:0] m_pc   [3];
    bit          m_fv   [3];
    bit          m_fl   [3];
    bit          m_ae   [3];
    int unsigned m_cnt  [3];
    int unsigned m_left [3];
    logic [63:0] p_rst  [3] = '{64'h1000, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0};
    int unsigned p_bub  [3] = '{1, 3, 0};
    int unsigned p_cmax [3] = '{65535, 15, 65535};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_target();
        logic [18:0] i19;
        longint      off;
        i19 = br_imm[18:0];
        case (br_kind)
            2'b00:   off = longint'($signed(br_imm)) * 4;
            2'b01:   off = longint'($signed(i19)) * 4;
            default: off = 0;
        endcase
        if (br_kind == 2'b10) return br_reg & ~64'd3;
        return br_pc + 64'(off);
    endfunction

    task automatic model_step();
        bit          redir;
        logic [63:0] t;
        redir = br_valid && br_taken && (br_kind != 2'b11);
        t     = ref_target();
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_pc[k] = p_rst[k]; m_fv[k] = 1; m_fl[k] = 0;
                m_ae[k] = 0; m_cnt[k] = 0; m_left[k] = 0;
            end else if (redir) begin
                m_pc[k]   = t;
                m_fl[k]   = 1;
                if (m_cnt[k] < p_cmax[k]) m_cnt[k]++;
                if (br_kind == 2'b10 && br_reg[1:0] != 2'b00) m_ae[k] = 1;
                m_left[k] = p_bub[k];
                m_fv[k]   = (m_left[k] == 0);
            end else if (stall) begin
                m_fl[k] = 0;
            end else if (m_left[k] > 0) begin
                m_left[k]--;
                m_fv[k] = (m_left[k] == 0);
                m_fl[k] = 0;
            end else begin
                m_pc[k] = m_pc[k] + 64'd4;
                m_fv[k] = 1;
                m_fl[k] = 0;
            end
        end
    endtask

    // One clock: advance model on the edge, compare all instances just after it
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("u0.pc", pc0, m_pc[0]);
        check("u0.fv", 64'(fv0), 64'(m_fv[0]));
        check("u0.flush", 64'(fl0), 64'(m_fl[0]));
        check("u0.aerr", 64'(ae0), 64'(m_ae[0]));
        check("u0.cnt", 64'(cnt0), 64'(m_cnt[0]));
        check("u1.pc", pc1, m_pc[1]);
        check("u1.fv", 64'(fv1), 64'(m_fv[1]));
        check("u1.flush", 64'(fl1), 64'(m_fl[1]));
        check("u1.aerr", 64'(ae1), 64'(m_ae[1]));
        check("u1.cnt", 64'(cnt1), 64'(m_cnt[1]));
        check("u2.pc", pc2, m_pc[2]);
        check("u2.fv", 64'(fv2), 64'(m_fv[2]));
        check("u2.flush", 64'(fl2), 64'(m_fl[2]));
        check("u2.aerr", 64'(ae2), 64'(m_ae[2]));
        check("u2.cnt", 64'(cnt2), 64'(m_cnt[2]));
    endtask

    task automatic idle();
        stall    = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
    endtask

    task automatic set_br(input logic [1:0] kind, input logic [63:0] bpc,
                          input logic [25:0] imm, input logic [63:0] rg);
        br_valid = 1'b1;
        br_taken = 1'b1;
        br_kind  = kind;
        br_pc    = bpc;
        br_imm   = imm;
        br_reg   = rg;
    endtask

    initial begin
        reset = 1'b0; br_kind = 2'b00; br_pc = '0; br_imm = '0; br_reg = '0;
        idle();

        // Reset, then sequential advance (u2 wraps past the top of memory)
        cyc(); cyc();
        check("rst.pc", pc0, 64'h1000);
        check("rst.fv", 64'(fv0), 64'd1);
        check("rst.flush", 64'(fl0), 64'd0);
        check("rst.cnt", 64'(cnt0), 64'd0);
        reset = 1'b1;
        repeat (4) cyc();
        check("adv.pc", pc0, 64'h1010);
        check("wrap.pc", pc2, 64'h0);

        // Backward B branch
        set_br(2'b00, 64'h2000, 26'h3FF_FFFC, 64'h0);
        cyc();
        check("b.pc", pc0, 64'h1FF0);
        check("b.flush", 64'(fl0), 64'd1);
        check("b.fv", 64'(fv0), 64'd0);
        idle();
        cyc();
        check("b.pc2", pc0, 64'h1FF0);
        check("b.fv2", 64'(fv0), 64'd1);
        check("b.flush2", 64'(fl0), 64'd0);
        cyc();
        check("b.pc3", pc0, 64'h1FF4);
        check("b.cnt", 64'(cnt0), 64'd1);

        // Forward CB with stall in the same cycle, then a not-taken resolution
        set_br(2'b01, 64'h400, 26'h10, 64'h0);
        stall = 1'b1;
        cyc();
        check("cb.pc", pc0, 64'h440);
        idle();
        br_valid = 1'b1;
        cyc();
        idle();
        cyc();

        // Misaligned BR: sticky error
        set_br(2'b10, 64'h0, 26'h0, 64'hDEAD_BEEF);
        cyc();
        check("br.pc", pc0, 64'hDEAD_BEEC);
        check("br.aerr", 64'(ae0), 64'd1);
        idle();
        repeat (100) cyc();
        check("br.sticky", 64'(ae0), 64'd1);

        // Back-to-back redirects and a stalled bubble on the 3-bubble instance
        set_br(2'b00, 64'h3000, 26'h8, 64'h0);
        cyc();
        idle();
        cyc();
        set_br(2'b00, 64'h5000, 26'h0, 64'h0);
        cyc();
        check("b2b.pc", pc1, 64'h5000);
        check("b2b.flush", 64'(fl1), 64'd1);
        idle();
        stall = 1'b1;
        repeat (2) cyc();
        stall = 1'b0;
        repeat (2) cyc();
        check("b2b.fv_lo", 64'(fv1), 64'd0);
        cyc();
        check("b2b.fv_hi", 64'(fv1), 64'd1);
        check("b2b.pc2", pc1, 64'h5000);

        // Reset in the middle of a bubble
        set_br(2'b00, 64'h8000, 26'h4, 64'h0);
        cyc();
        idle();
        reset = 1'b0;
        cyc();
        check("rstb.pc", pc1, 64'h1000);
        check("rstb.fv", 64'(fv1), 64'd1);
        check("rstb.aerr", 64'(ae0), 64'd0);
        reset = 1'b1;

        // Counter saturation on the narrow counter
        for (int i = 0; i < 20; i++) begin
            set_br(2'($urandom_range(1)), {$urandom, $urandom}, 26'($urandom), 64'h0);
            cyc();
        end
        idle();
        cyc();
        check("sat.cnt1", 64'(cnt1), 64'd15);
        check("sat.cnt0", 64'(cnt0), 64'd20);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(63) != 0);
            stall    = ($urandom_range(3) == 0);
            br_valid = ($urandom_range(2) == 0);
            br_taken = 1'($urandom);
            br_kind  = 2'($urandom);
            br_pc    = {$urandom, $urandom};
            br_imm   = 26'($urandom);
            br_reg   = {$urandom, $urandom};
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
